// File: rtl/mod_n_preset_ctrl.sv
// Modulo-N load-loop controller for a 74x161-style 4-bit counter (N = 2..16).
// Wrap tick is registered one clock after the counter's rco; ld_bar follows rco combinationally in RUN.
// Config uses valid/ready and is accepted only in IDLE; start/pause/abort are level-sampled each edge.
//
// Ports:
//   clk, clr_bar          clock and async active-low reset (shared with the counter)
//   cfg_valid/cfg_ready   modulus handshake; n_in carries the requested modulus (2..16)
//   start, pause, abort   run control (abort has highest priority)
//   qa..qd, rco           counter outputs and ripple carry
//   ld_bar, ent, enp      counter control pins; a..d counter preset data (a = LSB)
//   tick, wraps, sat      wrap pulse, saturating wrap count, sticky saturation flag
//   err, busy             sticky illegal-modulus flag, non-IDLE indicator
module mod_n_preset_ctrl #(
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              clr_bar,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [4:0]        n_in,
  input  logic              start,
  input  logic              pause,
  input  logic              abort,
  input  logic              qa,
  input  logic              qb,
  input  logic              qc,
  input  logic              qd,
  input  logic              rco,
  output logic              ld_bar,
  output logic              ent,
  output logic              enp,
  output logic              a,
  output logic              b,
  output logic              c,
  output logic              d,
  output logic              tick,
  output logic [WRAP_W-1:0] wraps,
  output logic              sat,
  output logic              err,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRELOAD,
    ST_RUN,
    ST_HOLD
  } state_t;

  localparam logic [WRAP_W-1:0] WRAPS_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};
  localparam logic [WRAP_W-1:0] WRAPS_MAX = '1;

  state_t              r_state;
  state_t              w_next;
  logic [4:0]          r_n;
  logic                r_err;
  logic                r_tick;
  logic [WRAP_W-1:0]   r_wraps;
  logic                r_sat;
  logic                w_xfer;
  logic                w_legal;
  logic                w_wrap;
  logic [3:0]          w_preset;
  logic                w_unused_bits;

  // The wrap decision relies solely on rco, so the count bits are not needed.
  // n_reg[4] only ever distinguishes 16 from 0, and both give preset 0.
  assign w_unused_bits = ^{qd, qc, qb, qa, r_n[4]};

  // (16 - n) mod 16 equals the two's complement of the low nibble of n.
  assign w_preset     = 4'd0 - r_n[3:0];
  assign {d, c, b, a} = w_preset;

  assign cfg_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign w_xfer    = cfg_valid & cfg_ready;
  assign w_legal   = (n_in >= 5'd2) && (n_in <= 5'd16);
  assign w_wrap    = (r_state == ST_RUN) & rco;

  assign tick  = r_tick;
  assign wraps = r_wraps;
  assign sat   = r_sat;
  assign err   = r_err;

  always_ff @(posedge clk or negedge clr_bar) begin
    if (!clr_bar) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    ld_bar = 1'b1;
    ent    = 1'b0;
    enp    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_PRELOAD;
      end
      ST_PRELOAD: begin
        ld_bar = 1'b0;
        ent    = 1'b1;
        enp    = 1'b1;
        w_next = ST_RUN;
      end
      ST_RUN: begin
        // Reload on terminal count so the period is exactly n clocks.
        ld_bar = ~rco;
        ent    = 1'b1;
        enp    = 1'b1;
        if (pause) w_next = ST_HOLD;
      end
      ST_HOLD: begin
        // ent stays high so rco remains meaningful while counting is frozen.
        ent = 1'b1;
        if (pause)      w_next = ST_HOLD;
        else if (start) w_next = ST_RUN;
      end
      default: w_next = ST_IDLE;
    endcase
    if (abort) w_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge clr_bar) begin
    if (!clr_bar) begin
      r_n   <= 5'd16;
      r_err <= 1'b0;
    end else if (w_xfer) begin
      if (w_legal) r_n   <= n_in;
      else         r_err <= 1'b1;
    end
  end

  // A wrap coinciding with abort is still counted: w_wrap ignores abort.
  always_ff @(posedge clk or negedge clr_bar) begin
    if (!clr_bar) begin
      r_tick  <= 1'b0;
      r_wraps <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_tick <= w_wrap;
      if (r_state == ST_PRELOAD) begin
        r_wraps <= '0;
        r_sat   <= 1'b0;
      end else if (w_wrap && (r_wraps != WRAPS_MAX)) begin
        r_wraps <= r_wraps + WRAPS_ONE;
        if (r_wraps == (WRAPS_MAX - WRAPS_ONE)) r_sat <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mod_n_preset_ctrl.sv
module tb_mod_n_preset_ctrl;

  localparam int WW = 4;

  logic          clk = 1'b0;
  logic          clr_bar = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [4:0]    n_in = 5'd0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          abort = 1'b0;
  logic          qa, qb, qc, qd, rco;
  logic          ld_bar, ent, enp, a, b, c, d, tick, sat, err, busy;
  logic [WW-1:0] wraps;

  logic [3:0]    cnt;
  logic [3:0]    q;
  int            cyc = 0;
  int            n_vec = 0;
  int            n_miss = 0;
  int            exp_q[$];
  int            mon_t;

  mod_n_preset_ctrl #(.WRAP_W(WW)) dut (
    .clk(clk), .clr_bar(clr_bar), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .n_in(n_in), .start(start), .pause(pause), .abort(abort),
    .qa(qa), .qb(qb), .qc(qc), .qd(qd), .rco(rco),
    .ld_bar(ld_bar), .ent(ent), .enp(enp), .a(a), .b(b), .c(c), .d(d),
    .tick(tick), .wraps(wraps), .sat(sat), .err(err), .busy(busy)
  );

  // Behavioural 74x161: async clear, sync load over count enable.
  always_ff @(posedge clk or negedge clr_bar) begin
    if (!clr_bar)         cnt <= 4'd0;
    else if (!ld_bar)     cnt <= {d, c, b, a};
    else if (ent && enp)  cnt <= cnt + 4'd1;
  end
  assign {qd, qc, qb, qa} = cnt;
  assign rco = ent & (cnt == 4'hF);
  assign q   = cnt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: every tick must match the next predicted wrap cycle.
  always @(negedge clk) begin
    if (tick === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL tick_unexpected: tick seen at cycle %0d, none expected", cyc);
      end else begin
        mon_t = exp_q.pop_front();
        if (mon_t != cyc) begin
          n_miss++;
          $display("FAIL tick_time: tick at cycle %0d, expected cycle %0d", cyc, mon_t);
        end
      end
    end
  end

  task automatic offer(input logic [4:0] n);
    cfg_valid = 1'b1; n_in = n;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic do_start(output int k);
    start = 1'b1; k = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_ticks(input int k, input int n, input int last);
    for (int t = k + 1 + n; t <= last; t += n) exp_q.push_back(t);
  endtask

  task automatic wait_until(input int cy);
    while (cyc < cy) @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if ({ld_bar, ent, enp, d, c, b, a, tick, sat, err, cfg_ready, busy} !== 12'b1000000000_10) begin
      n_miss++;
      $display("FAIL reset_outputs: got %b expected 100000000010",
               {ld_bar, ent, enp, d, c, b, a, tick, sat, err, cfg_ready, busy});
    end
    n_vec++;
    if (wraps !== '0) begin n_miss++; $display("FAIL reset_wraps: got %0d expected 0", wraps); end
    @(negedge clk); clr_bar = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_n10();
    int k;
    offer(5'd10);
    do_start(k);
    push_ticks(k, 10, k + 32);
    n_vec++;
    if (ld_bar !== 1'b0) begin n_miss++; $display("FAIL n10_preload_ld: ld_bar=%b expected 0", ld_bar); end
    @(negedge clk);
    n_vec++;
    if (q !== 4'd6 || ld_bar !== 1'b1) begin
      n_miss++; $display("FAIL n10_load: q=%0d ld_bar=%b expected q=6 ld_bar=1", q, ld_bar);
    end
    wait_until(k + 31);
    n_vec++;
    if (wraps !== 4'd3) begin n_miss++; $display("FAIL n10_wraps: got %0d expected 3", wraps); end
    do_abort();
    n_vec++;
    if (exp_q.size() != 0 || wraps !== 4'd3 || busy !== 1'b0) begin
      n_miss++; $display("FAIL n10_end: pending=%0d wraps=%0d busy=%b expected 0/3/0", exp_q.size(), wraps, busy);
    end
  endtask

  task automatic test_periods();
    int k;
    offer(5'd16);
    do_start(k);
    push_ticks(k, 16, k + 40);
    wait_until(k + 16);
    n_vec++;
    if (q !== 4'd15) begin n_miss++; $display("FAIL n16_top: q=%0d expected 15", q); end
    wait_until(k + 17);
    n_vec++;
    if (q !== 4'd0) begin n_miss++; $display("FAIL n16_wrap: q=%0d expected 0", q); end
    wait_until(k + 39);
    do_abort();
    n_vec++;
    if (exp_q.size() != 0) begin n_miss++; $display("FAIL n16_pending: %0d ticks missing, expected 0", exp_q.size()); end

    offer(5'd2);
    do_start(k);
    push_ticks(k, 2, k + 10);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      n_vec++;
      if (q !== ((i % 2 == 1) ? 4'd14 : 4'd15)) begin
        n_miss++; $display("FAIL n2_seq: step %0d q=%0d expected %0d", i, q, (i % 2 == 1) ? 14 : 15);
      end
    end
    wait_until(k + 9);
    do_abort();
    n_vec++;
    if (exp_q.size() != 0 || wraps !== 4'd4) begin
      n_miss++; $display("FAIL n2_end: pending=%0d wraps=%0d expected 0/4", exp_q.size(), wraps);
    end
  endtask

  task automatic test_illegal();
    int k;
    offer(5'd10);
    n_vec++;
    if (err !== 1'b0) begin n_miss++; $display("FAIL err_legal: err=%b expected 0", err); end
    offer(5'd1);
    n_vec++;
    if (err !== 1'b1 || cfg_ready !== 1'b1) begin
      n_miss++; $display("FAIL err_first: err=%b cfg_ready=%b expected 1/1", err, cfg_ready);
    end
    offer(5'd0);
    offer(5'd17);
    n_vec++;
    if (err !== 1'b1 || cfg_ready !== 1'b1) begin
      n_miss++; $display("FAIL err_sticky: err=%b cfg_ready=%b expected 1/1", err, cfg_ready);
    end
    do_start(k);
    push_ticks(k, 10, k + 22);
    @(negedge clk);
    n_vec++;
    if (q !== 4'd6) begin n_miss++; $display("FAIL err_nreg: q=%0d expected 6", q); end
    wait_until(k + 21);
    do_abort();
    n_vec++;
    if (exp_q.size() != 0) begin n_miss++; $display("FAIL err_pending: %0d ticks missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_pause();
    int k;
    do_start(k);
    exp_q.push_back(k + 16);
    wait_until(k + 3);
    n_vec++;
    if (q !== 4'd8) begin n_miss++; $display("FAIL pause_pre: q=%0d expected 8", q); end
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if (q !== 4'd9 || enp !== 1'b0 || ent !== 1'b1) begin
        n_miss++; $display("FAIL pause_hold: cycle %0d q=%0d enp=%b ent=%b expected 9/0/1", i, q, enp, ent);
      end
    end
    pause = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (q !== 4'd9 || enp !== 1'b1) begin
      n_miss++; $display("FAIL pause_resume: q=%0d enp=%b expected 9/1", q, enp);
    end
    @(negedge clk);
    n_vec++;
    if (q !== 4'd10) begin n_miss++; $display("FAIL pause_count: q=%0d expected 10", q); end
    wait_until(k + 19);
    do_abort();
    n_vec++;
    if (exp_q.size() != 0 || wraps !== 4'd1) begin
      n_miss++; $display("FAIL pause_end: pending=%0d wraps=%0d expected 0/1", exp_q.size(), wraps);
    end
  endtask

  task automatic test_saturate();
    int k;
    offer(5'd2);
    do_start(k);
    push_ticks(k, 2, k + 41);
    wait_until(k + 29);
    n_vec++;
    if (wraps !== 4'd14 || sat !== 1'b0) begin
      n_miss++; $display("FAIL sat_before: wraps=%0d sat=%b expected 14/0", wraps, sat);
    end
    wait_until(k + 31);
    n_vec++;
    if (wraps !== 4'd15 || sat !== 1'b1) begin
      n_miss++; $display("FAIL sat_reach: wraps=%0d sat=%b expected 15/1", wraps, sat);
    end
    wait_until(k + 40);
    do_abort();
    n_vec++;
    if (wraps !== 4'd15 || sat !== 1'b1 || exp_q.size() != 0) begin
      n_miss++; $display("FAIL sat_stick: wraps=%0d sat=%b pending=%0d expected 15/1/0", wraps, sat, exp_q.size());
    end
    do_start(k);
    @(negedge clk);
    n_vec++;
    if (wraps !== 4'd0 || sat !== 1'b0) begin
      n_miss++; $display("FAIL sat_clear: wraps=%0d sat=%b expected 0/0", wraps, sat);
    end
    do_abort();
  endtask

  task automatic test_back_to_back();
    int k;
    cfg_valid = 1'b1; n_in = 5'd4; start = 1'b1; k = cyc + 1;
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
    push_ticks(k, 4, k + 9);
    n_vec++;
    if (cfg_ready !== 1'b0 || busy !== 1'b1) begin
      n_miss++; $display("FAIL b2b_preload: cfg_ready=%b busy=%b expected 0/1", cfg_ready, busy);
    end
    @(negedge clk);
    n_vec++;
    if (q !== 4'd12) begin n_miss++; $display("FAIL b2b_newn: q=%0d expected 12", q); end
    wait_until(k + 3);
    cfg_valid = 1'b1; n_in = 5'd3;
    @(negedge clk);
    n_vec++;
    if (cfg_ready !== 1'b0) begin n_miss++; $display("FAIL b2b_stall: cfg_ready=%b expected 0", cfg_ready); end
    @(negedge clk);
    cfg_valid = 1'b0;
    wait_until(k + 8);
    do_abort();
    n_vec++;
    if (wraps !== 4'd2 || exp_q.size() != 0) begin
      n_miss++; $display("FAIL b2b_abort_wrap: wraps=%0d pending=%0d expected 2/0", wraps, exp_q.size());
    end
    do_start(k);
    @(negedge clk);
    n_vec++;
    if (q !== 4'd12) begin n_miss++; $display("FAIL b2b_kept: q=%0d expected 12", q); end
    do_abort();
  endtask

  task automatic test_reset_mid_run();
    int k;
    offer(5'd10);
    do_start(k);
    wait_until(k + 7);
    n_vec++;
    if (q !== 4'd12) begin n_miss++; $display("FAIL rst_pre: q=%0d expected 12", q); end
    #2 clr_bar = 1'b0;
    #1;
    n_vec++;
    if ({ld_bar, ent, enp, d, c, b, a, tick, sat, err, cfg_ready, busy} !== 12'b100000000010
        || wraps !== '0 || q !== 4'd0) begin
      n_miss++;
      $display("FAIL rst_async: got %b wraps=%0d q=%0d expected 100000000010 wraps=0 q=0",
               {ld_bar, ent, enp, d, c, b, a, tick, sat, err, cfg_ready, busy}, wraps, q);
    end
    @(negedge clk); clr_bar = 1'b1;
    @(negedge clk);
    n_vec++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      n_miss++; $display("FAIL rst_idle: cfg_ready=%b busy=%b expected 1/0", cfg_ready, busy);
    end
    do_start(k);
    push_ticks(k, 16, k + 18);
    wait_until(k + 16);
    n_vec++;
    if (q !== 4'd15) begin n_miss++; $display("FAIL rst_n16: q=%0d expected 15", q); end
    wait_until(k + 17);
    do_abort();
    n_vec++;
    if (exp_q.size() != 0) begin n_miss++; $display("FAIL rst_pending: %0d ticks missing, expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_n10();
    test_periods();
    test_illegal();
    test_pause();
    test_saturate();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
